// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - game-level sequencer for the snake datapath
//
// Runs the IDLE/PLAY/PAUSE/OVER game flow, times move steps at a
// length-dependent speed, queues turn requests so each step applies at
// most one turn, and keeps a saturating two-digit BCD score.
//
// Ports:
//   CLOCK        system clock
//   reset        synchronous active-high reset
//   start_pulse  one-cycle start / pause / resume request
//   left_pulse   one-cycle turn-left request
//   right_pulse  one-cycle turn-right request
//   collision    head-hit level from the datapath
//   food_eaten   one-cycle eat strobe from the datapath
//   len          current snake length from the datapath
//   step_en      one-cycle move strobe to the datapath
//   turn_left    turn left on this step, only alongside step_en
//   turn_right   turn right on this step, only alongside step_en
//   clear_snake  one-cycle datapath re-initialise strobe
//   state        0=IDLE 1=PLAY 2=PAUSE 3=OVER
//   speed_level  current speed level 0..3
//   score_bcd    score, tens digit in [7:4], units digit in [3:0]

module snake_game_ctrl #(
  parameter int BASE_PERIOD = 4194304,
  parameter int CNT_W       = 23,
  parameter int START_LEN   = 3,
  parameter int LVL_SHIFT   = 2,
  parameter int MAX_LEN     = 31
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       start_pulse,
  input  logic       left_pulse,
  input  logic       right_pulse,
  input  logic       collision,
  input  logic       food_eaten,
  input  logic [4:0] len,
  output logic       step_en,
  output logic       turn_left,
  output logic       turn_right,
  output logic       clear_snake,
  output logic [1:0] state,
  output logic [1:0] speed_level,
  output logic [7:0] score_bcd
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // Period needs one bit more than the timer: BASE_PERIOD may equal 2^CNT_W.
  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0] BASE_P      = PW'(BASE_PERIOD);
  localparam logic [4:0]    START_LEN_W = 5'(START_LEN);
  localparam logic [4:0]    MAX_LEN_W   = 5'(MAX_LEN);

  logic [1:0]       state_q, state_d;
  logic             step_en_q, step_en_d;
  logic             turn_left_q, turn_left_d;
  logic             turn_right_q, turn_right_d;
  logic             clear_snake_q, clear_snake_d;
  logic [1:0]       speed_level_q, speed_level_d;
  logic [7:0]       score_q, score_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  // Turn queue: entry 0 is the head, 1 = left, 0 = right.
  logic [1:0]       q_data_q, q_data_d;
  logic [1:0]       q_cnt_q, q_cnt_d;

  logic [4:0]    len_above;
  logic [4:0]    lvl_raw;
  logic [PW-1:0] period;
  logic [PW-1:0] period_m1;
  logic [PW-1:0] timer_ext;
  logic          enter_play;
  logic          step_fire;
  logic          push_req;
  logic          push_left;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Speed level is combinational from len so a speed-up affects the very
  // cycle it appears in; the speed_level output is its registered copy.
  always_comb begin
    len_above     = len - START_LEN_W;
    lvl_raw       = len_above >> LVL_SHIFT;
    speed_level_d = 2'd0;
    if (len >= START_LEN_W) begin
      if (lvl_raw > 5'd3) begin
        speed_level_d = 2'd3;
      end else begin
        speed_level_d = lvl_raw[1:0];
      end
    end
    period    = BASE_P >> speed_level_d;
    period_m1 = period - PW'(1);
    timer_ext = {1'b0, timer_q};
  end

  always_comb begin
    state_d       = state_q;
    step_en_d     = 1'b0;
    turn_left_d   = 1'b0;
    turn_right_d  = 1'b0;
    clear_snake_d = 1'b0;
    score_d       = score_q;
    timer_d       = timer_q;
    q_data_d      = q_data_q;
    q_cnt_d       = q_cnt_q;
    enter_play    = 1'b0;
    step_fire     = 1'b0;
    push_req      = 1'b0;
    push_left     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d    = ST_PLAY;
          enter_play = 1'b1;
        end
      end
      ST_PLAY: begin
        if (collision) begin
          state_d = ST_OVER;
        end else if (len >= MAX_LEN_W) begin
          state_d = ST_OVER;
        end else if (start_pulse) begin
          state_d = ST_PAUSE;
        end
        // The timer advances on every PLAY cycle, including the one that
        // leaves PLAY, so a pause/resume keeps the step cadence intact.
        // The >= compare makes a mid-count speed-up fire at once.
        if (timer_ext >= period_m1) begin
          timer_d   = '0;
          step_fire = (state_d == ST_PLAY);
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
        if (food_eaten && !collision) begin
          score_d = bcd_inc(score_q);
        end
        // Simultaneous left and right cancel each other.
        push_req  = left_pulse ^ right_pulse;
        push_left = left_pulse;
      end
      ST_PAUSE: begin
        if (start_pulse) begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_pulse) begin
          state_d    = ST_PLAY;
          enter_play = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pop before push so a request arriving on a step cycle is accepted
    // even when the queue was full.
    if (step_fire) begin
      step_en_d = 1'b1;
      if (q_cnt_q != 2'd0) begin
        turn_left_d  = q_data_q[0];
        turn_right_d = ~q_data_q[0];
        q_data_d     = {1'b0, q_data_q[1]};
        q_cnt_d      = q_cnt_q - 2'd1;
      end
    end
    if (push_req && (q_cnt_d != 2'd2)) begin
      if (q_cnt_d == 2'd0) begin
        q_data_d[0] = push_left;
      end else begin
        q_data_d[1] = push_left;
      end
      q_cnt_d = q_cnt_d + 2'd1;
    end

    if (enter_play) begin
      clear_snake_d = 1'b1;
      score_d       = 8'h00;
      timer_d       = '0;
      q_data_d      = 2'b00;
      q_cnt_d       = 2'd0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      step_en_q     <= 1'b0;
      turn_left_q   <= 1'b0;
      turn_right_q  <= 1'b0;
      clear_snake_q <= 1'b0;
      speed_level_q <= 2'd0;
      score_q       <= 8'h00;
      timer_q       <= '0;
      q_data_q      <= 2'b00;
      q_cnt_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      step_en_q     <= step_en_d;
      turn_left_q   <= turn_left_d;
      turn_right_q  <= turn_right_d;
      clear_snake_q <= clear_snake_d;
      speed_level_q <= speed_level_d;
      score_q       <= score_d;
      timer_q       <= timer_d;
      q_data_q      <= q_data_d;
      q_cnt_q       <= q_cnt_d;
    end
  end

  assign step_en     = step_en_q;
  assign turn_left   = turn_left_q;
  assign turn_right  = turn_right_q;
  assign clear_snake = clear_snake_q;
  assign state       = state_q;
  assign speed_level = speed_level_q;
  assign score_bcd   = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - scoreboard bench for snake_game_ctrl

module tb_snake_game_ctrl;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  logic       CLOCK;
  logic       reset;
  logic       start_pulse, left_pulse, right_pulse, collision, food_eaten;
  logic [4:0] len;
  logic       step_en, turn_left, turn_right, clear_snake;
  logic [1:0] state, speed_level;
  logic [7:0] score_bcd;

  snake_game_ctrl #(
    .BASE_PERIOD(16),
    .CNT_W(5)
  ) dut (
    .CLOCK(CLOCK),
    .reset(reset),
    .start_pulse(start_pulse),
    .left_pulse(left_pulse),
    .right_pulse(right_pulse),
    .collision(collision),
    .food_eaten(food_eaten),
    .len(len),
    .step_en(step_en),
    .turn_left(turn_left),
    .turn_right(turn_right),
    .clear_snake(clear_snake),
    .state(state),
    .speed_level(speed_level),
    .score_bcd(score_bcd)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit clr;
    bit stp;
    bit tl;
    bit tr;
  } strb_t;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [7:0] sc;
    logic [1:0] sp;
  } stat_t;

  strb_t sq[$];
  stat_t tq[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic void exp_strb(input int c, input bit clr, input bit stp,
                                   input bit tl, input bit tr);
    strb_t e;
    int i;
    e.cyc = c; e.clr = clr; e.stp = stp; e.tl = tl; e.tr = tr;
    i = 0;
    while (i < sq.size() && sq[i].cyc <= c) i++;
    sq.insert(i, e);
  endfunction

  function automatic void exp_stat(input int c, input logic [1:0] st,
                                   input logic [7:0] sc, input logic [1:0] sp);
    stat_t e;
    int i;
    e.cyc = c; e.st = st; e.sc = sc; e.sp = sp;
    i = 0;
    while (i < tq.size() && tq[i].cyc <= c) i++;
    tq.insert(i, e);
  endfunction

  // Monitor: compares strobes and status snapshots against the scoreboard.
  strb_t me;
  stat_t mt;
  always @(negedge CLOCK) begin
    while (sq.size() > 0 && sq[0].cyc < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_missing @%0d: got none, required clr=%0d step=%0d tl=%0d tr=%0d",
               sq[0].cyc, sq[0].clr, sq[0].stp, sq[0].tl, sq[0].tr);
      sq.delete(0);
    end
    if (step_en === 1'b1 || clear_snake === 1'b1 || turn_left === 1'b1 || turn_right === 1'b1) begin
      n_checks++;
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        me = sq[0];
        sq.delete(0);
        if ({clear_snake, step_en, turn_left, turn_right} !== {me.clr, me.stp, me.tl, me.tr}) begin
          n_fail++;
          $display("FAIL strobe @%0d: got clr=%0d step=%0d tl=%0d tr=%0d, required clr=%0d step=%0d tl=%0d tr=%0d",
                   cyc, clear_snake, step_en, turn_left, turn_right, me.clr, me.stp, me.tl, me.tr);
        end
      end else begin
        n_fail++;
        $display("FAIL strobe_unexpected @%0d: got clr=%0d step=%0d tl=%0d tr=%0d, required none",
                 cyc, clear_snake, step_en, turn_left, turn_right);
      end
    end
    while (tq.size() > 0 && tq[0].cyc <= cyc) begin
      mt = tq[0];
      tq.delete(0);
      n_checks++;
      if (mt.cyc != cyc || state !== mt.st || score_bcd !== mt.sc || speed_level !== mt.sp) begin
        n_fail++;
        $display("FAIL status @%0d: got state=%0d score=%h speed=%0d, required state=%0d score=%h speed=%0d",
                 mt.cyc, state, score_bcd, speed_level, mt.st, mt.sc, mt.sp);
      end
    end
  end

  task automatic next();
    @(posedge CLOCK);
    #1;
    start_pulse = 1'b0;
    left_pulse  = 1'b0;
    right_pulse = 1'b0;
    food_eaten  = 1'b0;
    collision   = 1'b0;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) next();
  endtask

  int s;

  initial begin
    reset = 1'b1; len = 5'd3;
    start_pulse = 1'b0; left_pulse = 1'b0; right_pulse = 1'b0;
    food_eaten = 1'b0; collision = 1'b0;

    // Reset, then idle with no start: nothing may strobe.
    repeat (3) next();
    reset = 1'b0;
    exp_stat(cyc, IDLE, 8'h00, 2'd0);
    exp_stat(cyc + 50, IDLE, 8'h00, 2'd0);
    exp_stat(cyc + 100, IDLE, 8'h00, 2'd0);
    goto_cyc(cyc + 100);

    // Start and base cadence, then collide.
    s = cyc + 2;
    exp_strb(s + 1, 1, 0, 0, 0);
    exp_stat(s + 1, PLAY, 8'h00, 2'd0);
    exp_strb(s + 17, 0, 1, 0, 0);
    exp_strb(s + 33, 0, 1, 0, 0);
    exp_strb(s + 49, 0, 1, 0, 0);
    exp_stat(s + 51, OVER, 8'h00, 2'd0);
    goto_cyc(s); start_pulse = 1'b1;
    goto_cyc(s + 50); collision = 1'b1;
    goto_cyc(s + 52);

    // Turn queue ordering, overflow, cancel, pop-then-push when full.
    s = cyc + 2;
    exp_strb(s + 1, 1, 0, 0, 0);
    exp_stat(s + 1, PLAY, 8'h00, 2'd0);
    exp_strb(s + 17, 0, 1, 1, 0);
    exp_strb(s + 33, 0, 1, 0, 1);
    exp_strb(s + 49, 0, 1, 0, 0);
    exp_strb(s + 65, 0, 1, 0, 0);
    exp_strb(s + 81, 0, 1, 1, 0);
    exp_strb(s + 97, 0, 1, 0, 1);
    exp_strb(s + 113, 0, 1, 1, 0);
    exp_strb(s + 129, 0, 1, 0, 0);
    exp_stat(s + 131, OVER, 8'h00, 2'd0);
    goto_cyc(s); start_pulse = 1'b1;
    goto_cyc(s + 2); left_pulse = 1'b1;
    goto_cyc(s + 3); right_pulse = 1'b1;
    goto_cyc(s + 4); left_pulse = 1'b1;
    goto_cyc(s + 50); left_pulse = 1'b1; right_pulse = 1'b1;
    goto_cyc(s + 66); left_pulse = 1'b1;
    goto_cyc(s + 67); right_pulse = 1'b1;
    goto_cyc(s + 80); left_pulse = 1'b1;
    goto_cyc(s + 130); collision = 1'b1;
    goto_cyc(s + 132);

    // Speed levels 1 and 3.
    s = cyc + 2;
    exp_strb(s + 1, 1, 0, 0, 0);
    exp_stat(s + 1, PLAY, 8'h00, 2'd1);
    exp_strb(s + 9, 0, 1, 0, 0);
    exp_strb(s + 17, 0, 1, 0, 0);
    exp_strb(s + 25, 0, 1, 0, 0);
    exp_stat(s + 26, PLAY, 8'h00, 2'd3);
    exp_strb(s + 27, 0, 1, 0, 0);
    exp_strb(s + 29, 0, 1, 0, 0);
    exp_strb(s + 31, 0, 1, 0, 0);
    exp_strb(s + 33, 0, 1, 0, 0);
    exp_stat(s + 35, OVER, 8'h00, 2'd3);
    exp_stat(s + 36, OVER, 8'h00, 2'd0);
    goto_cyc(s); start_pulse = 1'b1; len = 5'd7;
    goto_cyc(s + 25); len = 5'd15;
    goto_cyc(s + 34); collision = 1'b1;
    goto_cyc(s + 35); len = 5'd3;
    goto_cyc(s + 37);

    // Mid-count speed-up fires the step on the next cycle.
    s = cyc + 2;
    exp_strb(s + 1, 1, 0, 0, 0);
    exp_strb(s + 12, 0, 1, 0, 0);
    exp_stat(s + 12, PLAY, 8'h00, 2'd3);
    exp_stat(s + 13, PLAY, 8'h00, 2'd0);
    exp_strb(s + 28, 0, 1, 0, 0);
    exp_stat(s + 30, OVER, 8'h00, 2'd0);
    goto_cyc(s); start_pulse = 1'b1;
    goto_cyc(s + 11); len = 5'd15;
    goto_cyc(s + 12); len = 5'd3;
    goto_cyc(s + 29); collision = 1'b1;
    goto_cyc(s + 31);

    // Score: BCD carry, collision discards food, restart clears, saturation, win.
    s = cyc + 2;
    exp_strb(s + 1, 1, 0, 0, 0);
    exp_stat(s + 1, PLAY, 8'h00, 2'd0);
    exp_stat(s + 12, PLAY, 8'h10, 2'd0);
    exp_stat(s + 14, PLAY, 8'h12, 2'd0);
    exp_stat(s + 15, OVER, 8'h12, 2'd0);
    exp_stat(s + 16, OVER, 8'h12, 2'd0);
    exp_strb(s + 17, 1, 0, 0, 0);
    exp_stat(s + 17, PLAY, 8'h00, 2'd0);
    for (int k = 1; k <= 7; k++) exp_strb(s + 17 + 16 * k, 0, 1, 0, 0);
    exp_stat(s + 116, PLAY, 8'h98, 2'd0);
    exp_stat(s + 138, PLAY, 8'h99, 2'd0);
    exp_stat(s + 140, OVER, 8'h99, 2'd3);
    goto_cyc(s); start_pulse = 1'b1;
    for (int i = 0; i < 12; i++) begin
      goto_cyc(s + 2 + i); food_eaten = 1'b1;
    end
    goto_cyc(s + 14); collision = 1'b1; food_eaten = 1'b1;
    goto_cyc(s + 15); food_eaten = 1'b1; left_pulse = 1'b1;
    goto_cyc(s + 16); start_pulse = 1'b1;
    for (int i = 0; i < 120; i++) begin
      goto_cyc(s + 18 + i); food_eaten = 1'b1;
    end
    goto_cyc(s + 139); len = 5'd31;
    goto_cyc(s + 140); len = 5'd3;
    goto_cyc(s + 150);

    // Pause freezes timer, ignores inputs; resume keeps cadence without clear.
    s = cyc + 2;
    exp_strb(s + 1, 1, 0, 0, 0);
    exp_stat(s + 1, PLAY, 8'h00, 2'd0);
    exp_stat(s + 7, PAUSE, 8'h00, 2'd0);
    exp_stat(s + 100, PAUSE, 8'h00, 2'd0);
    exp_stat(s + 208, PLAY, 8'h00, 2'd0);
    exp_strb(s + 218, 0, 1, 0, 0);
    exp_stat(s + 220, OVER, 8'h00, 2'd0);
    goto_cyc(s); start_pulse = 1'b1;
    goto_cyc(s + 6); start_pulse = 1'b1;
    goto_cyc(s + 10); left_pulse = 1'b1;
    goto_cyc(s + 20); right_pulse = 1'b1;
    goto_cyc(s + 30); food_eaten = 1'b1;
    goto_cyc(s + 40); collision = 1'b1;
    goto_cyc(s + 207); start_pulse = 1'b1;
    goto_cyc(s + 219); collision = 1'b1;
    goto_cyc(s + 240);

    n_checks++;
    if (sq.size() != 0 || tq.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: got %0d strobes and %0d status entries pending, required 0",
               sq.size(), tq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
